// File: rtl/mul_seq_ctrl.sv
// Shift-and-add 64x64 multiplier sequencer that borrows the shared add/sub datapath.
// Produces the low LENGTH product bits, so signed and unsigned operands give the same result.
module mul_seq_ctrl #(
   parameter int LENGTH = 64,
   parameter int CW     = $clog2(LENGTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [LENGTH-1:0] op_a,
   input  logic [LENGTH-1:0] op_b,
   output logic              busy,
   output logic              done,
   output logic [LENGTH-1:0] result,
   output logic              zero,
   output logic              negative,
   output logic [LENGTH-1:0] add_a,
   output logic [LENGTH-1:0] add_b,
   output logic [2:0]        add_select,
   input  logic [LENGTH-1:0] add_sum
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0]     LAST_COUNT = CW'(LENGTH - 1);
   localparam logic [CW-1:0]     ONE_COUNT  = CW'(1);
   localparam logic [LENGTH-1:0] ZERO_WORD  = {LENGTH{1'b0}};

   state_t            state_r;
   logic [LENGTH-1:0] mcand_r;
   logic [LENGTH-1:0] mplier_r;
   logic [LENGTH-1:0] acc_r;
   logic [CW-1:0]     count_r;
   logic              busy_r;
   logic              done_r;
   logic [LENGTH-1:0] result_r;
   logic              zero_r;
   logic              negative_r;
   logic              last_s;

   // Final iteration: no multiplier bits remain above bit 0, or the full width has been walked.
   assign last_s = ((mplier_r >> 1) == ZERO_WORD) || (count_r == LAST_COUNT);

   // Adder operand steering; operands are held at zero outside RUN to keep the shared adder quiet.
   always_comb begin
      add_select = 3'b010;
      add_a      = ZERO_WORD;
      add_b      = ZERO_WORD;
      if (state_r == ST_RUN) begin
         add_a = acc_r;
         if (mplier_r[0]) begin
            add_b = mcand_r;
         end else begin
            add_b = ZERO_WORD;
         end
      end else begin
         add_a = ZERO_WORD;
         add_b = ZERO_WORD;
      end
   end

   // Sequencer state, datapath registers and registered status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         mcand_r    <= ZERO_WORD;
         mplier_r   <= ZERO_WORD;
         acc_r      <= ZERO_WORD;
         count_r    <= {CW{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         result_r   <= ZERO_WORD;
         zero_r     <= 1'b1;
         negative_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  mcand_r  <= op_a;
                  mplier_r <= op_b;
                  acc_r    <= ZERO_WORD;
                  count_r  <= {CW{1'b0}};
                  busy_r   <= 1'b1;
                  state_r  <= ST_RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               acc_r    <= add_sum;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               count_r  <= count_r + ONE_COUNT;
               if (last_s) begin
                  busy_r     <= 1'b0;
                  done_r     <= 1'b1;
                  result_r   <= add_sum;
                  zero_r     <= (add_sum == ZERO_WORD);
                  negative_r <= add_sum[LENGTH-1];
                  state_r    <= ST_DONE;
               end else begin
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  state_r <= ST_RUN;
               end
            end
            ST_DONE: begin
               // start is deliberately ignored here; it is only sampled back in IDLE
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign result   = result_r;
   assign zero     = zero_r;
   assign negative = negative_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed scenarios plus random operands
// compared against a product/latency model; the shared adder is modelled here.
module tb_mul_seq_ctrl;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic        zero;
   logic        negative;
   logic [63:0] add_a;
   logic [63:0] add_b;
   logic [2:0]  add_select;
   logic [63:0] add_sum;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   mul_seq_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .op_a       (op_a),
      .op_b       (op_b),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .zero       (zero),
      .negative   (negative),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_select (add_select),
      .add_sum    (add_sum)
   );

   // shared add/sub datapath: select[0] picks subtract
   assign add_sum = add_select[0] ? (add_a - add_b) : (add_a + add_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected RUN cycles: index of highest set multiplier bit plus one, minimum one
   function automatic int ref_len(input logic [63:0] b);
      for (int i = 63; i >= 0; i--) begin
         if (b[i]) return i + 1;
      end
      return 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // issues one start pulse and observes the operation; sample k is taken just after edge E0+k
   task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                         output int busy_n, output int done_at, output int done_n,
                         output logic [63:0] res, output logic z, output logic neg);
      busy_n  = 0;
      done_at = -1;
      done_n  = 0;
      res     = 64'hx;
      z       = 1'bx;
      neg     = 1'bx;
      op_a    = a;
      op_b    = b;
      start   = 1'b1;
      step();
      start   = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (done_at < 0) begin
               done_at = k;
               res     = result;
               z       = zero;
               neg     = negative;
            end
         end
         if (done_at >= 0 && k > done_at) break;
         step();
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b0;
      op_a    = 64'd0;
      op_b    = 64'd0;
      #12;
      chk_cnt++;
      if ({busy, done, zero, negative} !== 4'b0010) $display("FAIL reset_flags got=%b exp=0010", {busy, done, zero, negative});
      else pass_cnt++;
      chk_cnt++;
      if (result !== 64'd0) $display("FAIL reset_result got=%h exp=0", result);
      else pass_cnt++;
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int bn, da, dn; logic [63:0] r; logic z, n;
      run_op(64'd3, 64'd5, bn, da, dn, r, z, n);
      chk_cnt++;
      if (r !== 64'd15 || z !== 1'b0 || n !== 1'b0) $display("FAIL basic_result got=%0d z=%b n=%b exp=15 z=0 n=0", r, z, n);
      else pass_cnt++;
      chk_cnt++;
      if (bn !== 3 || da !== 3 || dn !== 1) $display("FAIL basic_timing busy=%0d done_at=%0d done_n=%0d exp=3/3/1", bn, da, dn);
      else pass_cnt++;
   endtask

   task automatic test_zero_mult();
      int bn, da, dn; logic [63:0] r; logic z, n;
      run_op(64'hDEAD_BEEF, 64'd0, bn, da, dn, r, z, n);
      chk_cnt++;
      if (r !== 64'd0 || z !== 1'b1 || n !== 1'b0) $display("FAIL zero_result got=%h z=%b n=%b exp=0 z=1 n=0", r, z, n);
      else pass_cnt++;
      chk_cnt++;
      if (bn !== 1 || da !== 1 || dn !== 1) $display("FAIL zero_timing busy=%0d done_at=%0d done_n=%0d exp=1/1/1", bn, da, dn);
      else pass_cnt++;
   endtask

   task automatic test_signed_wrap();
      int bn, da, dn; logic [63:0] r; logic z, n;
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, bn, da, dn, r, z, n);
      chk_cnt++;
      if (r !== 64'h8000_0000_0000_0000 || z !== 1'b0 || n !== 1'b1) $display("FAIL wrap_result got=%h z=%b n=%b exp=8000000000000000 z=0 n=1", r, z, n);
      else pass_cnt++;
      chk_cnt++;
      if (bn !== 64 || da !== 64 || dn !== 1) $display("FAIL wrap_timing busy=%0d done_at=%0d done_n=%0d exp=64/64/1", bn, da, dn);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int first_done = -1;
      int second_done = -1;
      logic [63:0] r1 = 64'hx;
      logic [63:0] r2 = 64'hx;
      logic busy_gap = 1'bx;
      op_a  = 64'd7;
      op_b  = 64'd6;
      start = 1'b1;
      step();
      for (int k = 0; k < 100; k++) begin
         if (k == 1) begin
            op_a = 64'd2;
            op_b = 64'd2;
         end
         if (k == 4) busy_gap = busy | done;
         if (done) begin
            if (first_done < 0) begin
               first_done = k;
               r1 = result;
            end else if (second_done < 0 && k > first_done + 1) begin
               second_done = k;
               r2 = result;
            end
         end
         if (second_done >= 0) break;
         step();
      end
      start = 1'b0;
      chk_cnt++;
      if (r1 !== 64'd42 || first_done !== 3) $display("FAIL ignored_start_first got=%0d at=%0d exp=42 at=3", r1, first_done);
      else pass_cnt++;
      chk_cnt++;
      if (busy_gap !== 1'b0) $display("FAIL ignored_start_idle_gap got=%b exp=0", busy_gap);
      else pass_cnt++;
      chk_cnt++;
      if (r2 !== 64'd4 || second_done !== 7) $display("FAIL ignored_start_second got=%0d at=%0d exp=4 at=7", r2, second_done);
      else pass_cnt++;
      step();
      step();
   endtask

   task automatic test_mid_reset();
      int bn, da, dn; logic [63:0] r; logic z, n;
      int done_seen = 0;
      op_a  = 64'd9;
      op_b  = 64'hFF;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      reset_n = 1'b0;
      #1;
      chk_cnt++;
      if (busy !== 1'b0 || result !== 64'd0 || zero !== 1'b1) $display("FAIL midreset_state busy=%b result=%h zero=%b exp=0/0/1", busy, result, zero);
      else pass_cnt++;
      #3;
      reset_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         if (done) done_seen++;
      end
      chk_cnt++;
      if (done_seen !== 0 || result !== 64'd0) $display("FAIL midreset_no_done done_seen=%0d result=%h exp=0/0", done_seen, result);
      else pass_cnt++;
      run_op(64'd9, 64'hFF, bn, da, dn, r, z, n);
      chk_cnt++;
      if (r !== 64'd2295 || bn !== 8 || da !== 8) $display("FAIL midreset_rerun got=%0d busy=%0d at=%0d exp=2295/8/8", r, bn, da);
      else pass_cnt++;
   endtask

   task automatic test_adder_if();
      logic [63:0] ka [3];
      logic [63:0] kb [3];
      logic [2:0]  ks [3];
      int waited = 0;
      chk_cnt++;
      if (add_a !== 64'd0 || add_b !== 64'd0 || add_select !== 3'b010) $display("FAIL adder_idle a=%h b=%h sel=%b exp=0/0/010", add_a, add_b, add_select);
      else pass_cnt++;
      op_a  = 64'd5;
      op_b  = 64'd4;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ka[k] = add_a;
         kb[k] = add_b;
         ks[k] = add_select;
         step();
      end
      chk_cnt++;
      if (kb[0] !== 64'd0 || kb[1] !== 64'd0 || ka[0] !== 64'd0 || ka[2] !== 64'd0) $display("FAIL adder_run_skip b0=%h b1=%h a0=%h a2=%h exp=0", kb[0], kb[1], ka[0], ka[2]);
      else pass_cnt++;
      chk_cnt++;
      if (kb[2] !== 64'd20 || ks[0] !== 3'b010 || ks[2] !== 3'b010) $display("FAIL adder_run_add b2=%0d sel=%b/%b exp=20 010", kb[2], ks[0], ks[2]);
      else pass_cnt++;
      while (!done && waited < 20) begin
         step();
         waited++;
      end
      chk_cnt++;
      if (result !== 64'd20 || done !== 1'b1) $display("FAIL adder_result got=%0d done=%b exp=20/1", result, done);
      else pass_cnt++;
      step();
   endtask

   task automatic test_random();
      int bn, da, dn; logic [63:0] r; logic z, n;
      logic [63:0] a, b, exp_p;
      int exp_n;
      for (int t = 0; t < 24; t++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom} >> $urandom_range(0, 63);
         if (t == 5) b = 64'd1;
         if (t == 9) b = 64'd0;
         if (t == 13) b[63] = 1'b1;
         exp_p = a * b;
         exp_n = ref_len(b);
         run_op(a, b, bn, da, dn, r, z, n);
         chk_cnt++;
         if (r !== exp_p || z !== (exp_p == 64'd0) || n !== exp_p[63]) $display("FAIL rand_result a=%h b=%h got=%h z=%b n=%b exp=%h", a, b, r, z, n, exp_p);
         else pass_cnt++;
         chk_cnt++;
         if (bn !== exp_n || da !== exp_n || dn !== 1) $display("FAIL rand_timing b=%h busy=%0d at=%0d dn=%0d exp=%0d", b, bn, da, dn, exp_n);
         else pass_cnt++;
         if ($urandom_range(0, 1) == 1) step();
      end
   endtask

   initial begin
      test_reset();
      test_adder_if();
      test_basic();
      test_zero_mult();
      test_signed_wrap();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
